// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic MAC processing element.
package systolic_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ACC_W_DEF  = 40;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } pe_state_t;

    function automatic logic signed [63:0] sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int width);
        return ~sat_max(width);
    endfunction

endpackage

// File: rtl/pipe_mult.sv
// Signed multiplier with MULT_PIPE register stages and a matching valid chain.
module pipe_mult
    import systolic_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MULT_PIPE = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       valid_i,
    input  logic signed [DATA_W-1:0]   a_i,
    input  logic signed [DATA_W-1:0]   b_i,
    output logic                       valid_o,
    output logic signed [2*DATA_W-1:0] p_o
);

    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0] prod_q [MULT_PIPE];
    logic [MULT_PIPE-1:0] vld_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int i = 0; i < MULT_PIPE; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= valid_i;
            prod_q[0] <= PW'(a_i) * PW'(b_i);
            for (int i = 1; i < MULT_PIPE; i++) begin
                vld_q[i]  <= vld_q[i-1];
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[MULT_PIPE-1];
    assign p_o     = prod_q[MULT_PIPE-1];

endmodule

// File: rtl/systolic_mac_pe.sv
// Self-sequencing systolic MAC PE; define SYSTOLIC_MAC_SAT_EN to saturate
// the accumulator on signed overflow instead of wrapping.
module systolic_mac_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int LEN_W     = 8,
    parameter int MULT_PIPE = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LEN_W-1:0]         k_len,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0]        a_out,
    output logic [DATA_W-1:0]        b_out,
    output logic                     valid_out,
    output logic [ACC_W-1:0]         c_out,
    output logic                     c_valid,
    input  logic                     c_ready,
    output logic                     overflow,
    output logic                     busy
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    pe_state_t               state_q, state_d;
    logic [LEN_W-1:0]        issue_q, issue_d;
    logic [LEN_W-1:0]        retire_q, retire_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic                    ovf_q, ovf_d;
    logic [DATA_W-1:0]       a_q, b_q;
    logic                    vout_q;

    logic                    issue;
    logic                    rvld;
    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]        addend, sum;
    logic                    add_ovf;

    assign issue = (state_q == ACCUM) && in_valid;

    pipe_mult #(
        .DATA_W    (DATA_W),
        .MULT_PIPE (MULT_PIPE)
    ) u_mult (
        .clk_i   (clk),
        .rst_ni  (reset),
        .valid_i (issue),
        .a_i     (a_in),
        .b_i     (b_in),
        .valid_o (rvld),
        .p_o     (prod)
    );

    assign addend  = ACC_W'(prod);
    assign sum     = acc_q + addend;
    assign add_ovf = (acc_q[ACC_W-1] == addend[ACC_W-1])
                  && (sum[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef SYSTOLIC_MAC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));
    logic [ACC_W-1:0] acc_add;
    assign acc_add = !add_ovf ? sum
                   : (addend[ACC_W-1] ? ACC_MIN : ACC_MAX);
`else
    logic [ACC_W-1:0] acc_add;
    assign acc_add = sum;
`endif

    always_comb begin
        state_d  = state_q;
        issue_d  = issue_q;
        retire_d = retire_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        if (rvld) begin
            retire_d = retire_q - ONE;
            acc_d    = acc_add;
            ovf_d    = ovf_q | add_ovf;
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    ovf_d    = 1'b0;
                    issue_d  = k_len;
                    retire_d = k_len;
                    state_d  = (k_len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    issue_d = issue_q - ONE;
                    if (issue_q == ONE) state_d = DRAIN;
                end
            end
            DRAIN: ;
            DONE: begin
                if (c_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Final retire closes the dot product on the same edge.
        if (rvld && retire_q == ONE
            && (state_q == ACCUM || state_q == DRAIN)) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            issue_q  <= '0;
            retire_q <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            vout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            issue_q  <= issue_d;
            retire_q <= retire_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            vout_q   <= in_valid;
            if (in_valid) begin
                a_q <= a_in;
                b_q <= b_in;
            end
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign valid_out = vout_q;
    assign c_out     = acc_q;
    assign c_valid   = (state_q == DONE);
    assign overflow  = ovf_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Directed bench for systolic_mac_pe: default build plus a 32-bit accumulator copy.
module tb_systolic_mac_pe;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start, start32;
    logic [7:0]         k_len;
    logic               in_valid;
    logic signed [15:0] a_in, b_in;
    logic               c_ready;

    logic [15:0] a_out, b_out, a_out32, b_out32;
    logic        valid_out, valid_out32;
    logic [39:0] c_out;
    logic [31:0] c_out32;
    logic        c_valid, c_valid32, overflow, overflow32, busy, busy32;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    systolic_mac_pe u_dut (
        .clk(clk), .reset(rst_n), .start(start), .k_len(k_len),
        .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
        .a_out(a_out), .b_out(b_out), .valid_out(valid_out),
        .c_out(c_out), .c_valid(c_valid), .c_ready(c_ready),
        .overflow(overflow), .busy(busy)
    );

    systolic_mac_pe #(.ACC_W(32)) u_dut32 (
        .clk(clk), .reset(rst_n), .start(start32), .k_len(k_len),
        .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
        .a_out(a_out32), .b_out(b_out32), .valid_out(valid_out32),
        .c_out(c_out32), .c_valid(c_valid32), .c_ready(c_ready),
        .overflow(overflow32), .busy(busy32)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pair(input int a, input int b);
        in_valid = 1'b1;
        a_in     = 16'(a);
        b_in     = 16'(b);
        tick();
    endtask

    logic [31:0] exp5;

    initial begin
        rst_n = 1'b0; start = 0; start32 = 0; k_len = '0;
        in_valid = 0; a_in = '0; b_in = '0; c_ready = 0;
        #12;
        chk("rst_cout",  64'(c_out), 64'd0);
        chk("rst_flags", {61'd0, c_valid, overflow, busy}, 64'd0);
        chk("rst_fwd",   {31'd0, valid_out, a_out, b_out}, 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: k_len=4 dot product
        start = 1; k_len = 8'd4; tick(); start = 0;
        pair(3, 5); pair(-2, 7); pair(10, 10); pair(1, -1);
        in_valid = 0;
        chk("t1_busy", {63'd0, busy}, 64'd1);
        chk("t1_cv_l0", {63'd0, c_valid}, 64'd0);
        tick();
        chk("t1_cv_l1", {63'd0, c_valid}, 64'd0);
        tick();
        chk("t1_cv", {63'd0, c_valid}, 64'd1);
        chk("t1_cout", 64'(c_out), 64'd100);
        chk("t1_ovf_busy", {62'd0, overflow, busy}, 64'b01);
        c_ready = 1; tick(); c_ready = 0;
        chk("t1_hs", {62'd0, c_valid, busy}, 64'd0);
        chk("t1_hold", 64'(c_out), 64'd100);

        // 2: forwarding in IDLE
        in_valid = 1; a_in = 16'sh1234; b_in = 16'shABCD; tick();
        in_valid = 0;
        chk("t2_fwd", {31'd0, valid_out, a_out, b_out},
            {31'd0, 1'b1, 16'h1234, 16'hABCD});
        chk("t2_acc", 64'(c_out), 64'd100);
        chk("t2_busy", {63'd0, busy}, 64'd0);
        tick();
        chk("t2_vo", {31'd0, valid_out, a_out, b_out},
            {31'd0, 1'b0, 16'h1234, 16'hABCD});

        // 3: k_len=0
        start = 1; k_len = 8'd0; tick(); start = 0;
        chk("t3_cv", {62'd0, c_valid, overflow}, 64'b10);
        chk("t3_cout", 64'(c_out), 64'd0);
        c_ready = 1; tick(); c_ready = 0;
        chk("t3_idle", {63'd0, busy}, 64'd0);

        // 4: gaps, backpressure, start in DONE
        start = 1; k_len = 8'd2; tick(); start = 0;
        in_valid = 0; tick();
        pair(6, 7);
        in_valid = 0; tick(); tick();
        pair(-3, 4);
        pair(100, 100);
        in_valid = 0;
        chk("t4_cv_l1", {63'd0, c_valid}, 64'd0);
        tick();
        chk("t4_cv", {63'd0, c_valid}, 64'd1);
        chk("t4_cout", 64'(c_out), 64'd30);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2); k_len = 8'd5;
            tick();
            chk("t4_hold", {23'd0, c_valid, c_out}, {23'd0, 1'b1, 40'd30});
        end
        start = 0;
        c_ready = 1; tick(); c_ready = 0;
        chk("t4_idle", {62'd0, c_valid, busy}, 64'd0);
        chk("t4_keep", 64'(c_out), 64'd30);

        // 5: overflow on 32-bit accumulator
        start32 = 1; k_len = 8'd3; tick(); start32 = 0;
        pair(-32768, -32768); pair(-32768, -32768); pair(-32768, -32768);
        in_valid = 0;
        tick(); tick();
`ifdef SYSTOLIC_MAC_SAT_EN
        exp5 = 32'h7FFFFFFF;
`else
        exp5 = 32'hC0000000;
`endif
        chk("t5_cv_ovf", {62'd0, c_valid32, overflow32}, 64'b11);
        chk("t5_cout", 64'(c_out32), 64'(exp5));
        chk("t5_dflt_idle", {63'd0, busy}, 64'd0);
        c_ready = 1; tick(); c_ready = 0;
        chk("t5_idle", {63'd0, busy32}, 64'd0);

        // 6: async reset mid-accumulation
        start = 1; k_len = 8'd4; tick(); start = 0;
        pair(2, 3); pair(5, 5);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_fwd", {31'd0, valid_out, a_out, b_out}, 64'd0);
        chk("t6_rst_c", {21'd0, c_valid, overflow, busy, c_out}, 64'd0);
        in_valid = 0;
        #10;
        rst_n = 1'b1;
        tick();
        start = 1; k_len = 8'd1; tick(); start = 0;
        pair(4, 4);
        in_valid = 0;
        tick();
        chk("t6_cv_l1", {63'd0, c_valid}, 64'd0);
        tick();
        chk("t6_cv", {63'd0, c_valid}, 64'd1);
        chk("t6_cout", 64'(c_out), 64'd16);
        c_ready = 1; tick(); c_ready = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
